// File: rtl/ca_correlator_pkg.sv
// ca_pkg: shared C/A code constants and correlator state encoding
package ca_pkg;
   localparam int CA_CODE_LENGTH = 1023;
   localparam logic [9:0] CA_LAST_SHIFT = 10'(CA_CODE_LENGTH - 1);
   typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, ACCUM = 2'd2} ca_state_t;
endpackage

// File: rtl/ca_correlator.sv
// ca_correlator: integrate-and-dump C/A despreader with one-deep valid/ready result register
//   clk, reset              : clock, synchronous active-high reset
//   enable                  : chip strobe qualifying code/sample/accumulate activity
//   code_in, code_shift     : local chip and its code phase (0..1022) from the generator
//   sample                  : signed received sample for this chip
//   start, stop             : arm correlation / abort to idle
//   acc_out, out_valid      : period sum and its valid flag
//   out_ready               : consumer accept
//   overrun                 : sticky, a result was overwritten unconsumed
//   busy                    : registered, high while aligning or accumulating
module ca_correlator
   import ca_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 4,
   parameter int ACC_WIDTH    = 15
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           code_in,
   input  logic [9:0]                     code_shift,
   input  logic signed [SAMPLE_WIDTH-1:0] sample,
   input  logic                           start,
   input  logic                           stop,
   output logic signed [ACC_WIDTH-1:0]    acc_out,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           overrun,
   output logic                           busy
);
   ca_state_t r_state, w_state_nxt;
   logic signed [ACC_WIDTH-1:0] r_acc, w_acc_nxt, w_term, w_sum, r_acc_out;
   logic r_out_valid, r_overrun, r_busy, w_dump;

   // widen before negating so that -(most negative sample) cannot wrap
   function automatic logic signed [ACC_WIDTH-1:0] chip_term(input logic c, input logic signed [SAMPLE_WIDTH-1:0] s);
      logic signed [ACC_WIDTH-1:0] x;
      x = {{(ACC_WIDTH-SAMPLE_WIDTH){s[SAMPLE_WIDTH-1]}}, s};
      return c ? -x : x;
   endfunction

   assign w_term = chip_term(code_in, sample);
   assign w_sum  = r_acc + w_term;

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_dump      = 1'b0;
      if (stop) begin
         w_state_nxt = IDLE;
         w_acc_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_acc_nxt   = '0;
               w_state_nxt = start ? ALIGN : IDLE;
            end
            ALIGN: if (enable && code_shift == '0) begin
               w_acc_nxt   = w_term;
               w_state_nxt = ACCUM;
            end
            ACCUM: if (enable) begin
               w_dump    = (code_shift == CA_LAST_SHIFT);
               w_acc_nxt = w_dump ? '0 : w_sum;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_acc_out   <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         // a dump always leaves a valid result; it is an overrun only if the old one was not taken this cycle
         if (w_dump) begin
            r_acc_out   <= w_sum;
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_ready) r_overrun <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign acc_out   = r_acc_out;
   assign out_valid = r_out_valid;
   assign overrun   = r_overrun;
   assign busy      = r_busy;
endmodule

// File: tb/tb_ca_correlator.sv
// tb_ca_correlator: scoreboard bench for ca_correlator against a chip-list reference model
module tb_ca_correlator;
   logic clk = 1'b0;
   logic reset = 1'b1, enable = 1'b0, code_in = 1'b0, start = 1'b0, stop = 1'b0, out_ready = 1'b0;
   logic [9:0] code_shift = '0;
   logic signed [3:0] sample = '0;
   logic signed [14:0] acc_out;
   logic out_valid, overrun, busy;

   ca_correlator dut (
      .clk(clk), .reset(reset), .enable(enable), .code_in(code_in), .code_shift(code_shift),
      .sample(sample), .start(start), .stop(stop), .acc_out(acc_out), .out_valid(out_valid),
      .out_ready(out_ready), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_chk = 0, n_dumps = 0, ph = 0;
   int sb[$];
   int m_terms[$];
   int m_state = 0, m_acc_out = 0, e_acc_out = 0;
   bit m_valid = 0, m_over = 0, m_busy = 0, e_valid = 0, e_over = 0, e_busy = 0, chk_en = 0;

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // m_state: 0 idle, 1 waiting for phase 0, 2 collecting chips; period sum = sum of collected chip terms
   task automatic cyc(input bit en, input bit c, input int s, input bit st, input bit sp, input bit rdy, input bit rs);
      int t, sum;
      bit dump;
      @(posedge clk);
      #2;
      e_valid = m_valid; e_over = m_over; e_busy = m_busy; e_acc_out = m_acc_out;
      reset = rs; enable = en; code_in = c; code_shift = ph[9:0]; sample = s[3:0];
      start = st; stop = sp; out_ready = rdy;
      t = c ? -s : s;
      dump = 0;
      sum = 0;
      if (rs) begin
         m_state = 0; m_terms.delete(); sb.delete();
         m_valid = 0; m_over = 0; m_acc_out = 0; m_busy = 0;
      end else begin
         if (sp) begin
            m_state = 0; m_terms.delete();
         end else if (m_state == 0) begin
            if (st) m_state = 1;
         end else if (m_state == 1) begin
            if (en && ph == 0) begin
               m_terms.delete(); m_terms.push_back(t); m_state = 2;
            end
         end else if (en) begin
            m_terms.push_back(t);
            if (ph == 1022) begin
               dump = 1;
               foreach (m_terms[i]) sum += m_terms[i];
               m_terms.delete();
            end
         end
         if (dump) begin
            if (m_valid && !rdy) begin
               m_over = 1;
               void'(sb.pop_back());
            end
            sb.push_back(sum);
            m_acc_out = sum; m_valid = 1; n_dumps++;
         end else if (m_valid && rdy) m_valid = 0;
         m_busy = (m_state != 0);
      end
      if (en) ph = (ph + 1) % 1023;
   endtask

   task automatic idle(input bit rdy);
      cyc(0, 0, 0, 0, 0, rdy, 0);
   endtask

   // cmode 0: code 0, 1: code 1, 2: code = phase parity; gaps of 1..maxgap idle cycles when maxgap>0
   task automatic chips_until_dump(input int s, input int cmode, input int maxgap, input bit rdy_last);
      int d0, k;
      bit c;
      d0 = n_dumps;
      k = 0;
      while (n_dumps == d0 && k < 5000) begin
         if (maxgap > 0) repeat ($urandom_range(1, maxgap)) idle(0);
         c = (cmode == 2) ? bit'(ph % 2) : bit'(cmode);
         cyc(1, c, s, 0, 0, rdy_last && ph == 1022, 0);
         k++;
      end
      if (n_dumps == d0) begin
         n_chk++;
         $display("FAIL dump_timeout: got no dump expected one");
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, e_valid);
         check("overrun", overrun, e_over);
         check("busy", busy, e_busy);
         check("acc_out", acc_out, e_acc_out);
         if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL xfer_unexpected: got %0d expected no transfer", acc_out);
            end else check("xfer", acc_out, sb.pop_front());
         end
      end
   end

   initial begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk_en = 1;
      // full period of +3
      cyc(0, 0, 0, 1, 0, 0, 0);
      chips_until_dump(3, 0, 0, 0);
      idle(0); @(negedge clk);
      check("p1_sum", acc_out, 3069);
      check("p1_valid", out_valid, 1);
      idle(1); idle(0); @(negedge clk);
      check("p1_consumed", out_valid, 0);
      // abort, wander to phase 500 in idle, arm there
      cyc(0, 0, 0, 0, 1, 0, 0);
      while (ph != 500) cyc(1, 1'($urandom), $urandom_range(0, 15) - 8, 0, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0, 0);
      chips_until_dump(1, 0, 0, 0);
      idle(0); @(negedge clk);
      check("p2_sum", acc_out, 1023);
      idle(1);
      // -(-8) across a full period, then alternating code
      chips_until_dump(-8, 1, 0, 0);
      idle(0); @(negedge clk);
      check("p3_max", acc_out, 8184);
      idle(1);
      chips_until_dump(5, 2, 0, 0);
      idle(0); @(negedge clk);
      check("p3_alt", acc_out, 5);
      // unconsumed result overwritten, then a dump coinciding with a transfer
      chips_until_dump(7, 0, 0, 0);
      idle(0); @(negedge clk);
      check("p4_over_sum", acc_out, 7161);
      check("p4_overrun", overrun, 1);
      chips_until_dump(2, 0, 0, 1);
      idle(0); @(negedge clk);
      check("p4_xfer_sum", acc_out, 2046);
      check("p4_xfer_valid", out_valid, 1);
      // stop mid-period
      while (ph != 600) cyc(1, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 1, 0, 0);
      idle(0); @(negedge clk);
      check("p5_busy", busy, 0);
      check("p5_kept", acc_out, 2046);
      repeat (600) cyc(1, 0, 1, 0, 0, 0, 0);
      // reset mid-accumulation
      cyc(0, 0, 0, 1, 0, 0, 0);
      repeat (1100) cyc(1, 0, 2, 0, 0, 0, 0);
      cyc(1, 0, 2, 0, 0, 0, 1);
      idle(0); @(negedge clk);
      check("p6_rst_acc", acc_out, 0);
      check("p6_rst_overrun", overrun, 0);
      // gapped chips
      cyc(0, 0, 0, 1, 0, 0, 0);
      chips_until_dump(3, 0, 5, 0);
      idle(0); @(negedge clk);
      check("p7_gap_sum", acc_out, 3069);
      // random traffic
      cyc(0, 0, 0, 1, 0, 0, 0);
      repeat (4000)
         cyc($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 15) - 8,
             $urandom_range(0, 199) == 0, $urandom_range(0, 1499) == 0, 1'($urandom), 0);
      idle(0); idle(0);
      @(negedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
